// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// fifo_arb_pkg : shared state encoding and index helper for fifo_wr_arbiter
// Revision     : 1.0
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // (idx + 1) mod n without a divider; valid for any n, power of two or not
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin picker, first request at or after ptr
// Revision: 1.0
// ============================================================================
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            found_o,
    output logic [ID_W-1:0] idx_o,
    output logic [N-1:0]    onehot_o
);

    logic [2*N-1:0]  w_dbl;
    logic [N-1:0]    w_rot;
    logic [ID_W-1:0] w_off;
    logic [ID_W:0]   w_sum;

    // Rotating the doubled vector puts ptr at bit 0, so the lowest set bit wins
    assign w_dbl = {req_i, req_i};
    assign w_rot = w_dbl[ptr_i +: N];

    always_comb begin
        found_o = 1'b0;
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found_o = 1'b1;
                w_off   = ID_W'(k);
            end
        end
        w_sum = {1'b0, ptr_i} + {1'b0, w_off};
        if (w_sum >= (ID_W + 1)'(N)) begin
            idx_o = ID_W'(w_sum - (ID_W + 1)'(N));
        end else begin
            idx_o = ID_W'(w_sum);
        end
        onehot_o = '0;
        if (found_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter : round-robin, burst-bounded sharing of one FIFO write port
// Revision        : 1.0
// ============================================================================
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic                        fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]       fifo_wr_data_o,
    input  logic                        fifo_wr_ready_i,
    output logic                        busy_o,
    output logic [ID_W-1:0]             owner_id_o
);
    import fifo_arb_pkg::*;

    localparam int C_CNT_W = $clog2(MAX_BURST + 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [C_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic [N_REQ-1:0]   w_win_oh;
    logic [N_REQ-1:0]   w_gnt;
    logic               w_xfer;
    logic [ID_W-1:0]    w_sel;

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (rr_ptr_q),
        .found_o  (w_found),
        .idx_o    (w_win),
        .onehot_o (w_win_oh)
    );

    // Grant is independent of ready; reset forces it low without waiting for a clock
    always_comb begin
        w_gnt = '0;
        if (!reset_i) begin
            if (state_q == ST_IDLE) begin
                w_gnt = w_win_oh;
            end else begin
                w_gnt[owner_q] = req_i[owner_q];
            end
        end
    end

    assign w_xfer = (|(req_i & w_gnt)) & fifo_wr_ready_i;
    assign w_sel  = (state_q == ST_IDLE && w_found) ? w_win : owner_q;

    assign gnt_o          = w_gnt;
    assign fifo_wr_en_o   = w_xfer;
    assign fifo_wr_data_o = req_data_i[w_sel * DATA_WIDTH +: DATA_WIDTH];
    assign busy_o         = (state_q == ST_OWNED);
    assign owner_id_o     = owner_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    owner_d = w_win;
                    if (w_xfer) begin
                        if (MAX_BURST == 1) begin
                            rr_ptr_d = ID_W'(wrap_inc(32'(w_win), N_REQ));
                        end else begin
                            state_d    = ST_OWNED;
                            beat_cnt_d = C_CNT_W'(1);
                        end
                    end
                end
            end
            ST_OWNED: begin
                if (!req_i[owner_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ID_W'(wrap_inc(32'(owner_q), N_REQ));
                end else if (w_xfer) begin
                    if (beat_cnt_q == C_CNT_W'(MAX_BURST - 1)) begin
                        state_d    = ST_IDLE;
                        rr_ptr_d   = ID_W'(wrap_inc(32'(owner_q), N_REQ));
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + C_CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire
